// File: rtl/key_seq_pkg.sv
// Shared types and constants for the key sequencer: FSM state encoding and entry width defaults.
package key_seq_pkg;

    localparam int KS_DATA_W = 7;
    localparam logic [KS_DATA_W-1:0] KS_CODE_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REC   = 3'd1,
        S_ISSUE = 3'd2,
        S_ACK   = 3'd3,
        S_WAIT  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/key_seq_buffer.sv
// Interval store: register array written at the write pointer, read combinationally at rd_addr_i.
module seq_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 7,
    parameter int CW     = 5,
    parameter int AW     = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CW-1:0]     count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (we_i) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            count_q  <= count_q + CW'(1);
        end
    end

    // Contents are not reset; Count alone says which entries are valid.
    always_ff @(posedge clk_i) begin
        if (we_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];
    assign count_o   = count_q;

endmodule

// File: rtl/key_sequencer.sv
// Records key-press spacing in units and replays it through the Auto_enable/Auto_data/Auto_idle handshake.
// Define KEY_SEQ_LOOP_EN to repeat playback until a Play pulse stops it.
module key_sequencer
    import key_seq_pkg::*;
#(
    parameter int UNIT_INTERVAL = 5000000,
    parameter int DEPTH         = 16,
    parameter int DATA_W        = KS_DATA_W
) (
    input  logic                       Sys_CLK,
    input  logic                       Sys_RST,
    input  logic                       Key_In,
    input  logic                       Record,
    input  logic                       Play,
    input  logic                       Auto_idle,
    output logic                       Auto_enable,
    output logic [DATA_W-1:0]          Auto_data,
    output logic                       Busy,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Overflow,
    output seq_state_e                 Dbg_State
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DIVW = (UNIT_INTERVAL > 0) ? $clog2(UNIT_INTERVAL + 1) : 1;
    localparam int UW   = DATA_W + 1;
    localparam logic [DIVW-1:0]   DIV_LAST = DIVW'(UNIT_INTERVAL);
    localparam logic [UW-1:0]     UNIT_SAT = {1'b1, {DATA_W{1'b0}}};
    localparam logic [DATA_W-1:0] CODE_MAX = {DATA_W{1'b1}};

`ifdef KEY_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    seq_state_e        state_q, state_d;
    logic              key_q, rec_q;
    logic [DIVW-1:0]   div_q, div_d;
    logic [UW-1:0]     units_q, units_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic              ovf_q, ovf_d;
    logic              en_q, en_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              stop_q, stop_d;

    logic              buf_clr, buf_we;
    logic [DATA_W-1:0] wr_code, rd_data;
    logic [CW-1:0]     count_w;
    logic              key_rise, rec_rise, rec_fall, tick, last, stop_now;

    assign key_rise = Key_In && !key_q;
    assign rec_rise = Record && !rec_q;
    assign rec_fall = !Record && rec_q;
    assign tick     = (div_q == DIV_LAST);
    assign last     = ((CW'(rd_q) + CW'(1)) == count_w);
    assign stop_now = LOOP_EN && (stop_q || Play);

    // A press after k full units stores k-1; 2^DATA_W units saturate to the all-ones code.
    assign wr_code = (units_q == '0)       ? '0 :
                     (units_q >= UNIT_SAT) ? CODE_MAX :
                                             DATA_W'(units_q - UW'(1));

    seq_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .CW     (CW),
        .AW     (AW)
    ) u_buf (
        .clk_i     (Sys_CLK),
        .rst_ni    (Sys_RST),
        .clr_i     (buf_clr),
        .we_i      (buf_we),
        .wr_data_i (wr_code),
        .rd_addr_i (rd_d),
        .rd_data_o (rd_data),
        .count_o   (count_w)
    );

    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            state_q <= S_IDLE;
            key_q   <= 1'b0;
            rec_q   <= 1'b0;
            div_q   <= '0;
            units_q <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= Key_In;
            rec_q   <= Record;
            div_q   <= div_d;
            units_q <= units_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
            en_q    <= en_d;
            data_q  <= data_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        units_d = units_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q;
        en_d    = 1'b0;
        data_d  = data_q;
        stop_d  = stop_q;
        buf_clr = 1'b0;
        buf_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (rec_rise) begin
                    state_d = S_REC;
                    div_d   = '0;
                    units_d = '0;
                    ovf_d   = 1'b0;
                    buf_clr = 1'b1;
                end else if (Play && (count_w != '0)) begin
                    state_d = S_ISSUE;
                    rd_d    = '0;
                end
            end
            S_REC: begin
                if (tick) begin
                    div_d = '0;
                    if (units_q != UNIT_SAT) units_d = units_q + UW'(1);
                end else begin
                    div_d = div_q + DIVW'(1);
                end
                if (rec_fall) begin
                    state_d = S_IDLE;
                end else if (key_rise) begin
                    div_d   = '0;
                    units_d = '0;
                    if (count_w == CW'(DEPTH)) ovf_d = 1'b1;
                    else                       buf_we = 1'b1;
                end
            end
            S_ISSUE: begin
                stop_d = stop_now;
                if (stop_now) begin
                    state_d = S_IDLE;
                end else if (Auto_idle) begin
                    en_d    = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                stop_d = stop_now;
                if (!Auto_idle) state_d = S_WAIT;
            end
            S_WAIT: begin
                stop_d = stop_now;
                if (Auto_idle) begin
                    if (stop_now) begin
                        state_d = S_IDLE;
                    end else if (last) begin
                        state_d = LOOP_EN ? S_ISSUE : S_IDLE;
                        rd_d    = '0;
                    end else begin
                        state_d = S_ISSUE;
                        rd_d    = rd_q + AW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Load the code as ISSUE is entered so it holds steady through ACK and WAIT.
        if (state_d == S_ISSUE) data_d = rd_data;
    end

    assign Auto_enable = en_q;
    assign Auto_data   = data_q;
    assign Busy        = (state_q != S_IDLE);
    assign Count       = count_w;
    assign Overflow    = ovf_q;
    assign Dbg_State   = state_q;

endmodule

// File: tb/tb_key_sequencer.sv
// Self-checking bench for key_sequencer with a behavioural auto-key responder; UNIT_INTERVAL=4, DEPTH=16.
module tb_key_sequencer;
    import key_seq_pkg::*;

    localparam int UI    = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 7;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          key = 1'b0;
    logic          rec = 1'b0;
    logic          play = 1'b0;
    logic          hold = 1'b0;
    logic          resp_busy = 1'b0;
    logic          auto_idle;
    logic          auto_en;
    logic [DW-1:0] auto_data;
    logic          busy;
    logic [CW-1:0] count;
    logic          ovf;
    seq_state_e    dbg;

    int            n_checks = 0;
    int            n_pass = 0;
    int            en_cnt = 0;
    int            resp_cnt = 0;
    logic [DW-1:0] resp_e;
    logic [DW-1:0] exp_q[$];

    assign auto_idle = !resp_busy && !hold;

    key_sequencer #(
        .UNIT_INTERVAL (UI),
        .DEPTH         (DEPTH),
        .DATA_W        (DW)
    ) dut (
        .Sys_CLK     (clk),
        .Sys_RST     (rst_n),
        .Key_In      (key),
        .Record      (rec),
        .Play        (play),
        .Auto_idle   (auto_idle),
        .Auto_enable (auto_en),
        .Auto_data   (auto_data),
        .Busy        (busy),
        .Count       (count),
        .Overflow    (ovf),
        .Dbg_State   (dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Responder: accepts a request, stays busy (code+1) units, then returns idle.
    always @(negedge clk) begin
        if (auto_en) begin
            en_cnt++;
            check("en_while_idle", auto_idle, 1);
            if (exp_q.size() == 0) begin
                check("unexpected_en", 1, 0);
            end else begin
                resp_e = exp_q.pop_front();
                check("auto_data", auto_data, resp_e);
`ifdef KEY_SEQ_LOOP_EN
                exp_q.push_back(resp_e);
`endif
            end
            resp_busy = 1'b1;
            resp_cnt  = (int'(auto_data) + 1) * (UI + 1);
        end else if (resp_busy) begin
            resp_cnt--;
            if (resp_cnt <= 0) resp_busy = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_code(input int k);
        if (k == 0) return '0;
        if (k - 1 > int'(KS_CODE_MAX)) return KS_CODE_MAX;
        return DW'(k - 1);
    endfunction

    task automatic rec_start();
        exp_q.delete();
        rec = 1'b1;
        cyc(1);
    endtask

    task automatic rec_stop();
        rec = 1'b0;
        cyc(2);
    endtask

    // Press detected 5k+3 clocks after the previous reference edge: mid-way through unit k.
    task automatic press_after(input int k, input bit keep);
        cyc(5 * k + 2);
        key = 1'b1;
        cyc(1);
        key = 1'b0;
        if (keep) exp_q.push_back(exp_code(k));
    endtask

    task automatic play_pulse();
        play = 1'b1;
        cyc(1);
        play = 1'b0;
    endtask

    task automatic wait_play(input int base, input int n, input int budget);
        int t;
        t = 0;
        while (en_cnt < base + n && t < budget) begin
            cyc(1);
            t++;
        end
`ifdef KEY_SEQ_LOOP_EN
        play_pulse();
`endif
        while (busy && t < budget) begin
            cyc(1);
            t++;
        end
        check("play_in_budget", (t < budget), 1);
        check("busy_after_play", busy, 0);
        check("en_count", en_cnt - base, n);
`ifdef KEY_SEQ_LOOP_EN
        exp_q.delete();
`else
        check("exp_q_drained", exp_q.size(), 0);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_en"}, auto_en, 0);
        check({tag, "_data"}, auto_data, 0);
    endtask

    initial begin
        int base;
        int k;
        int t;

        cyc(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        cyc(2);

        // Two presses: 3 units then 1 unit apart.
        rec_start();
        press_after(3, 1'b1);
        check("count_after_press", count, 1);
        press_after(1, 1'b1);
        rec_stop();
        check("rec2_count", count, 2);
        check("rec2_busy", busy, 0);
        check("rec2_ovf", ovf, 0);

        // Playback held off while the responder reports not idle.
        hold = 1'b1;
        base = en_cnt;
        play_pulse();
        cyc(6);
        check("busy_in_issue", busy, 1);
        check("no_en_while_held", en_cnt - base, 0);
        hold = 1'b0;
        wait_play(base, 2, 500);

        // Seventeen presses into sixteen slots.
        rec_start();
        for (int i = 0; i < 17; i++) begin
            k = $urandom_range(0, 3);
            press_after(k, (i < 16));
        end
        check("full_count", count, DEPTH);
        check("full_ovf", ovf, 1);
        rec_stop();
        check("ovf_sticky", ovf, 1);
        base = en_cnt;
        play_pulse();
        wait_play(base, 16, 3000);

        // Long interval saturates.
        rec_start();
        press_after(200, 1'b1);
        rec_stop();
        check("sat_count", count, 1);
        check("sat_ovf_cleared", ovf, 0);
        base = en_cnt;
        play_pulse();
        wait_play(base, 1, 2000);

        // Play with nothing stored, then Record and Play together.
        rec_start();
        rec_stop();
        check("empty_count", count, 0);
        base = en_cnt;
        play_pulse();
        cyc(3);
        check("empty_play_busy", busy, 0);
        check("empty_play_en", en_cnt - base, 0);
        rec  = 1'b1;
        play = 1'b1;
        cyc(1);
        play = 1'b0;
        check("rec_wins_state", dbg, S_REC);
        check("rec_wins_busy", busy, 1);
        rec_stop();

`ifdef KEY_SEQ_LOOP_EN
        // Looping replay of two entries, stopped after the fifth request.
        rec_start();
        press_after(1, 1'b1);
        press_after(2, 1'b1);
        rec_stop();
        base = en_cnt;
        play_pulse();
        wait_play(base, 5, 1000);
`endif

        // Reset asserted while waiting on the responder.
        rec_start();
        press_after(2, 1'b1);
        rec_stop();
        play_pulse();
        t = 0;
        while (dbg != S_WAIT && t < 200) begin
            cyc(1);
            t++;
        end
        check("reached_wait", dbg, S_WAIT);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        cyc(1);
        check_outputs_zero("rst_held");
        rst_n = 1'b1;
        cyc(1);
        exp_q.delete();
        base = en_cnt;
        play_pulse();
        cyc(3);
        check("post_rst_busy", busy, 0);
        check("post_rst_count", count, 0);
        check("post_rst_en", en_cnt - base, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/key_sequencer.md
# key_sequencer

- Records the spacing of manual key presses and replays them later through the light controller's auto-key interface.
- Acts as the initiator of the Auto_enable / Auto_data / Auto_idle handshake; the controller's auto-signal generator is the responder, which emits one Key pulse (Auto_data+1) units after each request.
- Sits beside the controller, fed by the same debounced key that drives Key_In.

## Interface
Parameters:
- UNIT_INTERVAL, 5000000: unit tick period minus one, in clocks (tick every UNIT_INTERVAL+1 clocks, 100 ms at 50 MHz); must match the responder.
- DEPTH, 16: number of interval entries stored.
- DATA_W, 7: entry width; equals the Auto_data width.

Ports:
- Sys_CLK  in  1  system clock.
- Sys_RST  in  1  reset; asynchronous, active-low.
- Key_In  in  1  debounced key level, synchronous to Sys_CLK; each rising edge is one press.
- Record  in  1  level; rising edge in IDLE starts a recording, falling edge ends it.
- Play  in  1  single-cycle start pulse.
- Auto_idle  in  1  responder idle flag.
- Auto_enable  out  1  single-cycle request pulse.
- Auto_data  out  DATA_W  delay code for the current request.
- Busy  out  1  high in any state other than IDLE.
- Count  out  $clog2(DEPTH+1)  number of stored entries.
- Overflow  out  1  sticky; a press arrived while the buffer was full.

All outputs reset to 0.

## Operation
States:
- IDLE, REC, ISSUE, ACK, WAIT.

Edge detection:
- Key and Record rising/falling edges come from one-cycle registered copies of the inputs.

Transitions:
- IDLE → REC on a Record rising edge. Entering REC clears Count, Overflow, write pointer, unit counter and tick divider.
- IDLE → ISSUE on Play when Count ≠ 0. Play with Count = 0 is ignored.
- If a Record rising edge and Play arrive in the same cycle, Record wins.

In REC:
- The tick divider runs; the unit counter saturates at 2^DATA_W.
- On a key press, the stored value is max(units,1)−1, saturated at 2^DATA_W−1. Then the unit counter and divider clear, the write pointer advances and Count increments.
- A press with Count = DEPTH is dropped and sets Overflow.
- A Record falling edge → IDLE; the partial interval is discarded.
- Play is ignored.

Playback:
- ISSUE: wait for Auto_idle=1, then drive Auto_data = entry[rd] and pulse Auto_enable for one cycle → ACK.
- ACK: wait for Auto_idle=0 → WAIT.
- WAIT: wait for Auto_idle=1, then advance rd. If rd reaches Count → IDLE, otherwise → ISSUE.
- Auto_data stays stable from ISSUE through WAIT.
- Record and Key_In are ignored during playback.

Reset mid-operation:
- Returns to IDLE.
- Count, Overflow and pointers clear; buffer contents become invalid.

## Timing
- Recorded value: a press k full units after the previous press, or after the Record edge for the first entry, stores k−1.
- Replay spacing: each request yields a Key pulse (k−1+1)·(UNIT_INTERVAL+1) clocks plus handshake overhead after the responder accepts. Overhead is 2–3 clocks per entry.
- Auto_enable rises one clock after ISSUE observes Auto_idle=1; it is never asserted while Auto_idle=0.
- Count updates on the clock after the press edge.
- Busy follows the state register with no added latency.

## Configuration
KEY_SEQ_LOOP_EN:
- Defined: after the last entry WAIT returns to ISSUE with rd=0, so the sequence repeats indefinitely. A Play pulse during ISSUE, ACK or WAIT stops playback: it finishes the outstanding handshake (WAIT completes), then goes to IDLE.
- Undefined: playback runs once; Play during playback is ignored.

## Structure
Package key_seq_pkg holds:
- the state enum;
- DATA_W default;
- the saturation constant 2^DATA_W−1.

Sub-module seq_buffer:
- DEPTH×DATA_W register array;
- write port with write pointer and Count;
- read port addressed by rd, combinational read.

The top level holds the FSM, tick divider, unit counter and edge detectors.

## Test plan
All scenarios use UNIT_INTERVAL=4 with a behavioural responder model.
- Record, presses 3 units then 1 unit apart, release Record → Count=2, entries 2 and 0, Busy low.
- Play → two Auto_enable pulses, Auto_data=2 then 0; each issued only after Auto_idle=1; Busy falls after the second Auto_idle rise.
- 17 presses with DEPTH=16 → Count=16, Overflow=1; entry 15 holds the 16th interval.
- Press 200 units after the Record edge → entry 0 = 127.
- Play with Count=0 → Busy stays low, no Auto_enable; Record and Play in the same cycle → REC.
- Reset asserted in WAIT → all outputs 0 next clock; a subsequent Play is ignored (Count=0).
- KEY_SEQ_LOOP_EN defined, 2 entries: replays entries 0,1,0,1,… until Play → stops after the current handshake.
